// File: rtl/kbd_text_pkg.sv
// Shared constants, defaults and state encoding for the keyboard-to-text-RAM writer.
package kbd_text_pkg;

    localparam int unsigned COLS_DEF   = 70;
    localparam int unsigned ROWS_DEF   = 30;
    localparam int unsigned COL_W_DEF  = 7;
    localparam int unsigned ROW_W_DEF  = 5;
    localparam int unsigned ADDR_W_DEF = 12;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_ENTER     = 8'h0D;
    localparam logic [7:0] ASCII_BACKSPACE = 8'h08;
    localparam logic [7:0] ASCII_PRINT_LO  = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI  = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CLR_LINE = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= ASCII_PRINT_LO) && (code <= ASCII_PRINT_HI);
    endfunction

endpackage

// File: rtl/kbd_text_writer_addr_map.sv
// Character RAM address map: phys_row*COLS + col, shared by every write path.
module text_addr_map
    import kbd_text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned COL_W  = COL_W_DEF,
    parameter int unsigned ROW_W  = ROW_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    output logic [ADDR_W-1:0] o_addr_c
);

    assign o_addr_c = ADDR_W'(i_row) * ADDR_W'(COLS) + ADDR_W'(i_col);

endmodule

// File: rtl/kbd_text_writer.sv
// Turns keyboard strobes into text-RAM writes; owns cursor, line wrap and
// circular-row scrolling with full-screen and single-line space clears.
module kbd_text_writer
    import kbd_text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COL_W  = COL_W_DEF,
    parameter int unsigned ROW_W  = ROW_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              key_valid,
    input  logic [7:0]        key_ascii,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [ROW_W-1:0]  top_row,
    output logic              busy,
    output logic              overflow
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t              r_state, w_state_next;
    logic                r_key_prev;
    logic                r_pend_valid, w_pend_valid_next;
    logic [7:0]          r_pend_code, w_pend_code_next;
    logic [COL_W-1:0]    r_col, w_col_next;
    logic [ROW_W-1:0]    r_row, w_row_next;
    logic [ROW_W-1:0]    r_top, w_top_next;
    logic [ROW_W-1:0]    r_clr_row, w_clr_row_next;
    logic [COL_W-1:0]    r_clr_col, w_clr_col_next;
    logic                r_wr_en, w_wr_en_next;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data, w_wr_data_next;
    logic                r_busy, w_busy_next;
    logic                r_overflow, w_overflow_next;

    logic                w_event;
    logic                w_serve;
    logic [7:0]          w_serve_code;
    logic                w_newline;
    logic [ROW_W-1:0]    w_map_row;
    logic [COL_W-1:0]    w_map_col;
    logic [ADDR_W-1:0]   w_map_addr;
    logic [ROW_W-1:0]    w_row_inc, w_row_dec, w_top_inc, w_last_row;

    assign w_event    = key_valid & ~r_key_prev;
    assign w_row_inc  = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
    assign w_row_dec  = (r_row == '0) ? LAST_ROW : r_row - ROW_W'(1);
    assign w_top_inc  = (r_top == LAST_ROW) ? '0 : r_top + ROW_W'(1);
    assign w_last_row = (r_top == '0) ? LAST_ROW : r_top - ROW_W'(1);

    text_addr_map #(
        .COLS   (COLS),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .i_row    (w_map_row),
        .i_col    (w_map_col),
        .o_addr_c (w_map_addr)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_CLR_ALL;
            r_key_prev   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_code  <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_top        <= '0;
            r_clr_row    <= '0;
            r_clr_col    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_key_prev   <= key_valid;
            r_pend_valid <= w_pend_valid_next;
            r_pend_code  <= w_pend_code_next;
            r_col        <= w_col_next;
            r_row        <= w_row_next;
            r_top        <= w_top_next;
            r_clr_row    <= w_clr_row_next;
            r_clr_col    <= w_clr_col_next;
            r_wr_en      <= w_wr_en_next;
            r_wr_addr    <= w_wr_en_next ? w_map_addr : r_wr_addr;
            r_wr_data    <= w_wr_data_next;
            r_busy       <= w_busy_next;
            r_overflow   <= w_overflow_next;
        end
    end

    // Next-state, cursor and write-request logic.
    always_comb begin
        w_state_next      = r_state;
        w_pend_valid_next = r_pend_valid;
        w_pend_code_next  = r_pend_code;
        w_col_next        = r_col;
        w_row_next        = r_row;
        w_top_next        = r_top;
        w_clr_row_next    = r_clr_row;
        w_clr_col_next    = r_clr_col;
        w_wr_en_next      = 1'b0;
        w_wr_data_next    = r_wr_data;
        w_busy_next       = 1'b0;
        w_overflow_next   = r_overflow;
        w_map_row         = r_row;
        w_map_col         = r_col;
        w_serve           = 1'b0;
        w_serve_code      = key_ascii;
        w_newline         = 1'b0;

        case (r_state)
            ST_CLR_ALL: begin
                w_busy_next    = 1'b1;
                w_wr_en_next   = 1'b1;
                w_wr_data_next = ASCII_SPACE;
                w_map_row      = r_clr_row;
                w_map_col      = r_clr_col;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_next = '0;
                    if (r_clr_row == LAST_ROW) begin
                        w_clr_row_next = '0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_clr_row_next = r_clr_row + ROW_W'(1);
                    end
                end else begin
                    w_clr_col_next = r_clr_col + COL_W'(1);
                end
            end

            ST_CLR_LINE: begin
                w_busy_next    = 1'b1;
                w_wr_en_next   = 1'b1;
                w_wr_data_next = ASCII_SPACE;
                w_map_row      = r_row;
                w_map_col      = r_clr_col;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_clr_col_next = r_clr_col + COL_W'(1);
                end
            end

            default: begin
                // Pending key has priority; a coincident new key takes its slot.
                if (r_pend_valid) begin
                    w_serve           = 1'b1;
                    w_serve_code      = r_pend_code;
                    w_pend_valid_next = w_event;
                    if (w_event) w_pend_code_next = key_ascii;
                end else if (w_event) begin
                    w_serve = 1'b1;
                end

                if (w_serve) begin
                    if (is_printable(w_serve_code)) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_data_next = w_serve_code;
                        if (r_col == LAST_COL) w_newline = 1'b1;
                        else                   w_col_next = r_col + COL_W'(1);
                    end else if (w_serve_code == ASCII_ENTER) begin
                        w_newline = 1'b1;
                    end else if (w_serve_code == ASCII_BACKSPACE) begin
                        if (r_col != '0) begin
                            w_col_next     = r_col - COL_W'(1);
                            w_map_col      = r_col - COL_W'(1);
                            w_wr_en_next   = 1'b1;
                            w_wr_data_next = ASCII_SPACE;
                        end else if (r_row != r_top) begin
                            w_row_next     = w_row_dec;
                            w_col_next     = LAST_COL;
                            w_map_row      = w_row_dec;
                            w_map_col      = LAST_COL;
                            w_wr_en_next   = 1'b1;
                            w_wr_data_next = ASCII_SPACE;
                        end
                    end
                end

                if (w_newline) begin
                    w_col_next = '0;
                    w_row_next = w_row_inc;
                    if (r_row == w_last_row) begin
                        w_top_next     = w_top_inc;
                        w_clr_col_next = '0;
                        w_state_next   = ST_CLR_LINE;
                    end
                end
            end
        endcase

        // Keys arriving during a clear are parked once; a second one is lost.
        if ((r_state != ST_IDLE) && w_event) begin
            if (!r_pend_valid) begin
                w_pend_valid_next = 1'b1;
                w_pend_code_next  = key_ascii;
            end else begin
                w_overflow_next = 1'b1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign top_row    = r_top;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
